// File: rtl/fmisc_result_buffer.sv
// rtl/fmisc_result_buffer.sv - FIFO of misc-unit results awaiting register writeback.
// Optional zero-latency bypass when empty: define FMISC_BUFFER_BYPASS_EN.
module fmisc_result_buffer #(
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic [31:0]          result_i,
    input  logic                 data_valid_i,
    input  logic                 dest_reg_file_i,
    input  logic [4:0]           reg_dest_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    input  logic                 writeback_ready_i,
    output logic [31:0]          result_o,
    output logic                 data_valid_o,
    output logic                 dest_reg_file_o,
    output logic [4:0]           reg_dest_o,
    output logic [TAG_WIDTH-1:0] tag_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 32 + 1 + 5 + TAG_WIDTH;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          full, empty, push, pop, bypass;
    logic [EW-1:0] in_entry, head_entry;

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign in_entry   = {result_i, dest_reg_file_i, reg_dest_i, tag_i};
    assign head_entry = mem_q[rd_ptr_q];

`ifdef FMISC_BUFFER_BYPASS_EN
    // Empty buffer with a ready consumer: hand the input straight through, store nothing.
    assign bypass = empty & data_valid_i & writeback_ready_i;
    always_comb begin
        data_valid_o = !empty | data_valid_i;
        if (empty)
            {result_o, dest_reg_file_o, reg_dest_o, tag_o} = in_entry;
        else
            {result_o, dest_reg_file_o, reg_dest_o, tag_o} = head_entry;
    end
`else
    assign bypass       = 1'b0;
    assign data_valid_o = !empty;
    assign {result_o, dest_reg_file_o, reg_dest_o, tag_o} = head_entry;
`endif

    assign pop  = !empty & writeback_ready_i;
    assign push = data_valid_i & (!full | pop) & !bypass;

    assign full_o     = full;
    assign empty_o    = empty;
    assign overflow_o = overflow_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (data_valid_i & full & !pop);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)
                count_d = count_q + 1'b1;
            else if (pop && !push)
                count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage carries no reset; only the pointers define what is live.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i && !rst_i)
            mem_q[wr_ptr_q] <= in_entry;
    end

endmodule

// File: tb/tb_fmisc_result_buffer.sv
// tb/tb_fmisc_result_buffer.sv - queue-model bench for fmisc_result_buffer.
module tb_fmisc_result_buffer;
    localparam int DEPTH = 4;
    localparam int TW    = 6;

    logic          clk = 1'b0;
    logic          rst_i, flush_i, data_valid_i, dest_reg_file_i, writeback_ready_i;
    logic [31:0]   result_i;
    logic [4:0]    reg_dest_i;
    logic [TW-1:0] tag_i;
    logic [31:0]   result_o;
    logic          data_valid_o, dest_reg_file_o, full_o, empty_o, overflow_o;
    logic [4:0]    reg_dest_o;
    logic [TW-1:0] tag_o;

    fmisc_result_buffer #(.DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .result_i(result_i), .data_valid_i(data_valid_i),
        .dest_reg_file_i(dest_reg_file_i), .reg_dest_i(reg_dest_i), .tag_i(tag_i),
        .writeback_ready_i(writeback_ready_i),
        .result_o(result_o), .data_valid_o(data_valid_o),
        .dest_reg_file_o(dest_reg_file_o), .reg_dest_o(reg_dest_o), .tag_o(tag_o),
        .full_o(full_o), .empty_o(empty_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   r;
        logic          f;
        logic [4:0]    d;
        logic [TW-1:0] t;
    } ent_t;

    ent_t q[$];
    logic ov_m;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic byp;
        ent_t h;
        byp = 1'b0;
`ifdef FMISC_BUFFER_BYPASS_EN
        if (q.size() == 0 && data_valid_i) byp = 1'b1;
`endif
        chk("empty", empty_o, q.size() == 0);
        chk("full", full_o, q.size() == DEPTH);
        chk("overflow", overflow_o, ov_m);
        chk("data_valid", data_valid_o, (q.size() != 0) || byp);
        if (q.size() != 0 || byp) begin
            if (byp) begin
                h.r = result_i; h.f = dest_reg_file_i; h.d = reg_dest_i; h.t = tag_i;
            end else begin
                h = q[0];
            end
            chk("result", result_o, h.r);
            chk("file", dest_reg_file_o, h.f);
            chk("reg", reg_dest_o, h.d);
            chk("tag", tag_o, h.t);
        end
    endtask

    task automatic model_step();
        logic full_m, empty_m, byp, pop, push;
        ent_t e;
        full_m  = (q.size() == DEPTH);
        empty_m = (q.size() == 0);
        byp     = 1'b0;
`ifdef FMISC_BUFFER_BYPASS_EN
        byp = empty_m && data_valid_i && writeback_ready_i;
`endif
        pop  = !empty_m && writeback_ready_i;
        push = data_valid_i && (!full_m || pop) && !byp;
        if (data_valid_i && full_m && !pop) ov_m = 1'b1;
        if (flush_i) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                e.r = result_i; e.f = dest_reg_file_i; e.d = reg_dest_i; e.t = tag_i;
                q.push_back(e);
            end
        end
    endtask

    // Called at a negedge: drive, check pre-edge outputs, clock, advance model.
    task automatic cycle(input logic v, input logic [31:0] r, input logic f,
                         input logic [4:0] d, input logic [TW-1:0] t,
                         input logic rdy, input logic fl);
        data_valid_i = v; result_i = r; dest_reg_file_i = f; reg_dest_i = d; tag_i = t;
        writeback_ready_i = rdy; flush_i = fl;
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 32'h0, 1'b0, 5'd0, '0, rdy, 1'b0);
    endtask

    initial begin
        logic v, rdy, fl;
        rst_i = 1'b1; flush_i = 1'b0; data_valid_i = 1'b0; writeback_ready_i = 1'b0;
        result_i = '0; dest_reg_file_i = 1'b0; reg_dest_i = '0; tag_i = '0;
        q.delete(); ov_m = 1'b0;
        #12;
        chk("rst_empty", empty_o, 1'b1);
        chk("rst_full", full_o, 1'b0);
        chk("rst_dv", data_valid_o, 1'b0);
        chk("rst_ovf", overflow_o, 1'b0);
        @(negedge clk);
        rst_i = 1'b0;

        // single result round trip
        cycle(1'b1, 32'h3F800000, 1'b1, 5'd3, 6'd5, 1'b1, 1'b0);
`ifndef FMISC_BUFFER_BYPASS_EN
        chk("rt_dv", data_valid_o, 1'b1);
        chk("rt_result", result_o, 32'h3F800000);
        chk("rt_tag", tag_o, 6'd5);
`endif
        idle(1'b1);
        chk("rt_empty_after", empty_o, 1'b1);

        // full buffer with simultaneous push and pop
        for (int i = 1; i <= 4; i++)
            cycle(1'b1, 32'h40000000 + i, 1'b0, 5'(i), 6'(i), 1'b0, 1'b0);
        chk("fill_full", full_o, 1'b1);
        cycle(1'b1, 32'h40400000, 1'b1, 5'd7, 6'd7, 1'b1, 1'b0);
        chk("pp_full", full_o, 1'b1);
        chk("pp_ovf", overflow_o, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // overflow: fifth push dropped while stalled
        for (int i = 1; i <= 4; i++)
            cycle(1'b1, 32'h41000000 + i, 1'b1, 5'(i + 10), 6'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'hDEADBEEF, 1'b0, 5'd9, 6'd9, 1'b0, 1'b0);
        chk("ovf_set", overflow_o, 1'b1);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // flush with three stored entries plus a push
        for (int i = 1; i <= 3; i++)
            cycle(1'b1, 32'h42000000 + i, 1'b0, 5'(i), 6'(i + 20), 1'b0, 1'b0);
        cycle(1'b1, 32'h42000009, 1'b0, 5'd9, 6'd29, 1'b0, 1'b1);
        chk("flush_empty", empty_o, 1'b1);
        chk("flush_dv", data_valid_o, 1'b0);
        chk("flush_ovf_kept", overflow_o, 1'b1);

        // asynchronous reset between edges with two entries held
        for (int i = 1; i <= 2; i++)
            cycle(1'b1, 32'h43000000 + i, 1'b1, 5'(i), 6'(i + 30), 1'b0, 1'b0);
        data_valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        chk("arst_empty", empty_o, 1'b1);
        chk("arst_dv", data_valid_o, 1'b0);
        chk("arst_ovf", overflow_o, 1'b0);
        q.delete(); ov_m = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        idle(1'b0);

`ifdef FMISC_BUFFER_BYPASS_EN
        cycle(1'b1, 32'hBF800000, 1'b0, 5'd1, 6'd1, 1'b1, 1'b0);
        chk("byp_empty_next", empty_o, 1'b1);
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            v   = 1'($urandom_range(0, 2) != 0);
            rdy = 1'($urandom_range(0, 2) == 0);
            fl  = 1'($urandom_range(0, 24) == 0);
            if (fl && q.size() == DEPTH) v = 1'b0;
            cycle(v, $urandom, 1'($urandom), 5'($urandom), 6'($urandom), rdy, fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
